// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunSel op codes, flag bit positions and the sequencer state type.
package alu_pkg;

    localparam int unsigned FUNSEL_WIDTH = 5;
    localparam int unsigned FLAG_WIDTH   = 4;

    // FunSel[4] selects 32-bit operation; FunSel[3:0] is the op code.
    localparam int unsigned FUNSEL_W32_BIT = 4;

    localparam logic [3:0] OP_A    = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_NOTB = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDC = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_LSL  = 4'b1011;
    localparam logic [3:0] OP_LSR  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;
    localparam logic [3:0] OP_CSL  = 4'b1110;
    localparam logic [3:0] OP_CSR  = 4'b1111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Command/response front end for the ALU: issues one FunSel N times with ALUOut fed back
// into A, then returns the final result and the ALU's flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [FUNSEL_WIDTH-1:0] cmd_funsel_i,
    input  logic [DATA_WIDTH-1:0]   cmd_a_i,
    input  logic [DATA_WIDTH-1:0]   cmd_b_i,
    input  logic [COUNT_WIDTH-1:0]  cmd_count_i,
    input  logic                    cmd_wf_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [FLAG_WIDTH-1:0]   rsp_flags_o,

    input  logic                    abort_i,
    output logic                    busy_o,

    output logic [DATA_WIDTH-1:0]   alu_a_o,
    output logic [DATA_WIDTH-1:0]   alu_b_o,
    output logic [FUNSEL_WIDTH-1:0] alu_funsel_o,
    output logic                    alu_wf_o,
    input  logic [DATA_WIDTH-1:0]   alu_out_i,
    input  logic [FLAG_WIDTH-1:0]   flags_i
);

    seq_state_e               state_q, state_d;
    logic                     init_q;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    b_q, b_d;
    logic [FUNSEL_WIDTH-1:0]  funsel_q, funsel_d;
    logic                     wf_q, wf_d;
    logic [COUNT_WIDTH-1:0]   steps_q, steps_d;
    logic [DATA_WIDTH-1:0]    res_q, res_d;
    logic                     cmd_ready;

    // init_q keeps CmdReady low until the first edge after reset release.
    assign cmd_ready = (state_q == StIdle) && init_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        funsel_d = funsel_q;
        wf_d     = wf_q;
        steps_d  = steps_q;
        res_d    = res_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready) begin
                    acc_d    = cmd_a_i;
                    b_d      = cmd_b_i;
                    funsel_d = cmd_funsel_i;
                    wf_d     = cmd_wf_i;
                    steps_d  = (cmd_count_i == '0) ? COUNT_WIDTH'(1) : cmd_count_i;
                    state_d  = StExec;
                end
            end
            StExec: begin
                steps_d = steps_q - COUNT_WIDTH'(1);
                if (abort_i) begin
                    state_d = StIdle;
                end else if (steps_q == COUNT_WIDTH'(1)) begin
                    // Final result goes to res_q so ALU_A holds its last driven value.
                    res_d   = alu_out_i;
                    state_d = StResp;
                end else begin
                    acc_d = alu_out_i;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            init_q   <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            funsel_q <= '0;
            wf_q     <= 1'b0;
            steps_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            acc_q    <= acc_d;
            b_q      <= b_d;
            funsel_q <= funsel_d;
            wf_q     <= wf_d;
            steps_q  <= steps_d;
            res_q    <= res_d;
        end
    end

    assign cmd_ready_o  = cmd_ready;
    assign busy_o       = (state_q != StIdle);
    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_data_o   = res_q;
    // ALU WF is low in RESP, so its registered flags stay stable while stalled.
    assign rsp_flags_o  = (state_q == StResp) ? flags_i : '0;
    assign alu_a_o      = acc_q;
    assign alu_b_o      = b_q;
    assign alu_funsel_o = funsel_q;
    assign alu_wf_o     = wf_q && (state_q == StExec);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and a command-level model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_wf;
    logic [4:0]  cmd_funsel, cmd_count;
    logic [31:0] cmd_a, cmd_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        abort, busy;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_funsel;
    logic        alu_wf;
    logic [3:0]  alu_flags = 4'b0000;
    logic [35:0] alu_nx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(32), .COUNT_WIDTH(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_funsel_i(cmd_funsel),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_count_i(cmd_count), .cmd_wf_i(cmd_wf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_flags_o(rsp_flags), .abort_i(abort), .busy_o(busy),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_funsel_o(alu_funsel), .alu_wf_o(alu_wf),
        .alu_out_i(alu_out), .flags_i(alu_flags)
    );

    // One ALU step: returns {Z,C,N,O, result}. C and O persist for ops that do not define them.
    function automatic logic [35:0] alu_fn(input logic [4:0] fs, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] fin);
        logic [32:0] s;
        logic [31:0] r;
        logic c, o;
        c = fin[FLAG_C];
        o = fin[FLAG_O];
        s = '0;
        r = a;
        case (fs[3:0])
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4, 4'h5: begin
                s = {1'b0, a} + {1'b0, b} + ((fs[3:0] == 4'h5) ? {32'd0, c} : 33'd0);
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h6: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: r = ~(a & b);
            4'hB: begin r = a << 1; c = a[31]; end
            4'hC: begin r = a >> 1; c = a[0]; end
            4'hD: begin r = $signed(a) >>> 1; c = a[0]; end
            4'hE: begin r = {a[30:0], a[31]}; c = a[31]; end
            default: begin r = {a[0], a[31:1]}; c = a[0]; end
        endcase
        return {(r == 32'd0), c, r[31], o, r};
    endfunction

    // Command-level reference: apply the op max(count,1) times, flags only move when WF is set.
    function automatic logic [35:0] model(input logic [4:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] cnt,
                                          input logic wf, input logic [3:0] prior);
        int n;
        logic [31:0] r;
        logic [3:0] f;
        logic [35:0] t;
        n = (cnt == 5'd0) ? 1 : int'(cnt);
        r = a;
        f = prior;
        for (int i = 0; i < n; i++) begin
            t = alu_fn(fs, r, b, f);
            if (wf) f = t[35:32];
            r = t[31:0];
        end
        return {f, r};
    endfunction

    assign alu_nx  = alu_fn(alu_funsel, alu_a, alu_b, alu_flags);
    assign alu_out = alu_nx[31:0];
    always @(posedge clk) if (alu_wf) alu_flags <= alu_nx[35:32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name, output bit ok);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = cmd_ready;
        if (!ok) chk({name, ".accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input string name, input logic [4:0] fs, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] cnt, input logic wf,
                           input int delay, input logic noise, input logic [31:0] exp_d,
                           input logic [3:0] exp_f);
        int n, lat, wfc;
        bit ok, side_ok, stable;
        logic [31:0] last_a, d0;
        logic [3:0] f0;
        n = (cnt == 5'd0) ? 1 : int'(cnt);
        @(negedge clk);
        cmd_funsel = fs; cmd_a = a; cmd_b = b; cmd_count = cnt; cmd_wf = wf;
        cmd_valid = 1'b1;
        abort = noise;
        wait_ready(name, ok);
        if (!ok) begin
            cmd_valid = 1'b0;
            abort = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b0;
        chk({name, ".a_first"}, alu_a, a);
        lat = 1; wfc = 0; side_ok = 1'b1; last_a = a;
        while (!rsp_valid && lat < 40) begin
            if (alu_wf) wfc++;
            if (alu_b !== b || alu_funsel !== fs) side_ok = 1'b0;
            last_a = alu_a;
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(n + 1));
        chk({name, ".wf_cycles"}, 32'(wfc), wf ? 32'(n) : 32'd0);
        chk({name, ".alu_b_funsel"}, {31'd0, side_ok}, 32'd1);
        chk({name, ".data"}, rsp_data, exp_d);
        chk({name, ".flags"}, {28'd0, rsp_flags}, {28'd0, exp_f});
        chk({name, ".a_hold"}, alu_a, last_a);
        chk({name, ".resp_ctl"}, {29'd0, cmd_ready, alu_wf, busy}, 32'b001);
        d0 = rsp_data;
        f0 = rsp_flags;
        stable = 1'b1;
        abort = noise;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || rsp_flags !== f0 || cmd_ready) stable = 1'b0;
        end
        chk({name, ".stall_stable"}, {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        abort = 1'b0;
        chk({name, ".back_idle"}, {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
    endtask

    typedef struct {
        logic [4:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  cnt;
        logic        wf;
        int          delay;
        logic [31:0] ed;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok, stable, seen;
        logic [35:0] m;
        logic [31:0] d0;
        logic [3:0] f0;
        logic [4:0] fs;
        logic [31:0] ra, rb;
        logic [4:0] rc;
        logic rw;

        vecs[0] = '{5'b10100, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1, 0, 32'h0000_0000, 4'b1100};
        vecs[1] = '{5'b11100, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1, 32'h0800_0000, 4'b0000};
        vecs[2] = '{5'b10001, 32'd5, 32'h1234_5678, 5'd0, 1'b1, 0, 32'h1234_5678, 4'b0000};
        vecs[3] = '{5'b10100, 32'd7, 32'd8, 5'd2, 1'b1, 2, 32'h0000_0017, 4'b0000};
        vecs[4] = '{5'b10110, 32'd5, 32'd5, 5'd1, 1'b0, 0, 32'h0000_0000, 4'b0000};
        vecs[5] = '{5'b11011, 32'd1, 32'd0, 5'd31, 1'b1, 0, 32'h8000_0000, 4'b0010};
        vecs[6] = '{5'b11111, 32'd1, 32'd0, 5'd1, 1'b1, 3, 32'h8000_0000, 4'b0110};
        vecs[7] = '{5'b11101, 32'h8000_0000, 32'd0, 5'd0, 1'b1, 0, 32'hC000_0000, 4'b0010};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_funsel = '0; cmd_a = '0; cmd_b = '0; cmd_count = '0;
        cmd_wf = 1'b0; rsp_ready = 1'b0; abort = 1'b0;
        #12;
        chk("reset.ctl", {28'd0, cmd_ready, rsp_valid, busy, alu_wf}, 32'd0);
        chk("reset.alu_a", alu_a, 32'd0);
        chk("reset.alu_b", alu_b, 32'd0);
        chk("reset.funsel", {27'd0, alu_funsel}, 32'd0);
        chk("reset.rsp", rsp_data | {28'd0, rsp_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset.ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("reset.ready_after_edge", {31'd0, cmd_ready}, 32'd1);

        foreach (vecs[i]) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].cnt,
                    vecs[i].wf, vecs[i].delay, 1'b0, vecs[i].ed, vecs[i].ef);
        end

        // CmdValid held through a stalled response: no accept until after the handshake.
        @(negedge clk);
        cmd_funsel = 5'b10100; cmd_a = 32'd1; cmd_b = 32'd2; cmd_count = 5'd2; cmd_wf = 1'b1;
        cmd_valid = 1'b1;
        wait_ready("hold", ok);
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("hold.rsp_seen", {31'd0, seen}, 32'd1);
        chk("hold.data", rsp_data, 32'd5);
        d0 = rsp_data; f0 = rsp_flags; stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || rsp_flags !== f0 || cmd_ready) stable = 1'b0;
        end
        chk("hold.stable_no_accept", {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold.idle_after_hs", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        @(negedge clk);
        chk("hold.second_accept", {30'd0, busy, cmd_ready}, 32'b10);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("hold.second_data", rsp_data, 32'd5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Abort in the second EXEC cycle of an 8-step command.
        cmd_funsel = 5'b10100; cmd_a = 32'd3; cmd_b = 32'd4; cmd_count = 5'd8; cmd_wf = 1'b1;
        cmd_valid = 1'b1;
        wait_ready("abort", ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.ctl", {28'd0, alu_wf, cmd_ready, busy, rsp_valid}, 32'b0100);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort.no_rsp", {31'd0, seen}, 32'd0);

        // Asynchronous reset in the middle of a 16-step command.
        cmd_funsel = 5'b11011; cmd_a = 32'd1; cmd_b = 32'd0; cmd_count = 5'd16; cmd_wf = 1'b1;
        cmd_valid = 1'b1;
        wait_ready("rst_mid", ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid.ctl", {28'd0, alu_wf, rsp_valid, busy, cmd_ready}, 32'd0);
        chk("rst_mid.alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.ready", {31'd0, cmd_ready}, 32'd1);
        m = model(5'b10100, 32'h10, 32'h20, 5'd1, 1'b1, alu_flags);
        run_cmd("post_rst", 5'b10100, 32'h10, 32'h20, 5'd1, 1'b1, 0, 1'b0, m[31:0], m[35:32]);
        m = model(5'b10110, 32'd9, 32'd9, 5'd1, 1'b0, alu_flags);
        run_cmd("post_rst_wf0", 5'b10110, 32'd9, 32'd9, 5'd1, 1'b0, 1, 1'b0, m[31:0],
                m[35:32]);

        for (int i = 0; i < 40; i++) begin
            fs = 5'($urandom);
            ra = $urandom;
            rb = $urandom;
            rc = 5'($urandom_range(0, 31));
            rw = 1'($urandom);
            m = model(fs, ra, rb, rc, rw, alu_flags);
            run_cmd($sformatf("rnd%0d", i), fs, ra, rb, rc, rw, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), m[31:0], m[35:32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
